// File: rtl/cond_logic.sv
// Conditional-execution stage: architectural NZCV register, condition
// evaluation, side-effect gating and executed/squashed instruction counters.
module cond_logic #(
  parameter int unsigned COUNT_W     = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [3:0]         cond,
  input  logic [1:0]         flag_w,
  input  logic               pc_src_in,
  input  logic               reg_write_in,
  input  logic               mem_write_in,
  input  logic [3:0]         alu_flags,
  input  logic               clr_counters,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_write,
  output logic               cond_ex,
  output logic [3:0]         flags,
  output logic [COUNT_W-1:0] exec_count,
  output logic [COUNT_W-1:0] squash_count
);

  logic [3:0]         flags_q, flags_d;
  logic [COUNT_W-1:0] exec_q, exec_d;
  logic [COUNT_W-1:0] squash_q, squash_d;
  logic               cond_pass;
  logic               n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Decode the condition field against the registered flags only; the
  // current instruction's ALU flags must never influence its own condition.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // 1111 is reserved and treated as never
    endcase
  end

  // Gate decoder side effects with zero latency.
  always_comb begin
    cond_ex   = instr_valid & cond_pass;
    pc_src    = pc_src_in    & cond_ex;
    reg_write = reg_write_in & cond_ex;
    mem_write = mem_write_in & cond_ex;
  end

  // Next-state for flags (per-pair write enables) and the wrapping counters.
  always_comb begin
    flags_d  = flags_q;
    exec_d   = exec_q;
    squash_d = squash_q;
    if (cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
    if (clr_counters) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (instr_valid) begin
      if (cond_ex) exec_d   = exec_q + COUNT_W'(1);
      else         squash_d = squash_q + COUNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= RESET_FLAGS;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign flags        = flags_q;
  assign exec_count   = exec_q;
  assign squash_count = squash_q;

endmodule
